spi_arbiter: RTL and testbench

Sequencing and arbitration controller for the byte-level SPI engine (`spi`). It shares one engine between two requesters, for example the CPU peripheral port and the boot loader. It runs multi-byte transactions of 1..256 bytes under a single chip select, with programmable CS setup and hold delays. The engine's `start`/`busy`/`data_rx` interface is instantiated alongside this block, and this block's `spi_*` ports connect to it directly.

---
 rtl/spi_arbiter_pkg.sv | 25 ++
 rtl/spi_arbiter.sv | 123 ++++++++++++
 tb/tb_spi_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_arbiter_pkg.sv
// Shared definitions for the two-requester SPI sequencing arbiter.
// Latency: n/a (types, constants and the round-robin pick only).
// Backpressure: n/a.
package spi_arbiter_pkg;

    localparam int N_REQ = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_LOAD  = 3'd2,
        ST_RUN   = 3'd3,
        ST_HOLD  = 3'd4
    } state_t;

    // Round-robin pick between two requesters; returns the winning index.
    // With both requesting, the one that did not win last time goes next.
    function automatic logic rr_pick(input logic [N_REQ-1:0] req, input logic last);
        if (req == 2'b11) begin
            return ~last;
        end
        return req[1];
    endfunction

endpackage

// File: rtl/spi_arbiter.sv
// Shares one byte-level SPI engine between two requesters; runs 1..256-byte bursts under one cs_n.
// Latency: grant 1 cycle after req; done at 2*CS_DELAY + 19*(len+1) cycles after grant.
// Backpressure: requests wait in IDLE while the engine is busy; the engine paces bytes via spi_busy.
module spi_arbiter
    import spi_arbiter_pkg::*;
#(
    parameter int CS_DELAY = 2
) (
    input  logic             raw_clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    input  logic [7:0]       len0,
    input  logic [7:0]       len1,
    input  logic [7:0]       tx0,
    input  logic [7:0]       tx1,
    output logic [N_REQ-1:0] grant,
    output logic [N_REQ-1:0] tx_take,
    output logic [N_REQ-1:0] rx_valid,
    output logic [7:0]       rx_data,
    output logic [N_REQ-1:0] done,
    output logic             cs_n,
    output logic             spi_start,
    output logic [7:0]       spi_data_tx,
    input  logic             spi_busy,
    input  logic [7:0]       spi_data_rx
);

    localparam logic [3:0] DLY_LAST = 4'(CS_DELAY - 1);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] count;
    logic [3:0] dcnt;
    logic       last;
    logic       win;
    logic       grant_ok;

    // The engine has no reset, so a grant also waits for it to go idle.
    assign grant_ok = (req != '0) && !spi_busy;
    assign win      = rr_pick(req, last);

    // State register; reset drops straight to IDLE so cs_n rises asynchronously.
    always_ff @(posedge raw_clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state selection.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (grant_ok) state_nxt = ST_SETUP;
            ST_SETUP: if (dcnt == DLY_LAST) state_nxt = ST_LOAD;
            ST_LOAD:  state_nxt = ST_RUN;
            ST_RUN:   if (!spi_busy) state_nxt = (count == 8'd0) ? ST_HOLD : ST_LOAD;
            ST_HOLD:  if (dcnt == DLY_LAST) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Outputs decoded from state: chip select, engine kick and byte hand-off.
    always_comb begin
        cs_n        = (state == ST_IDLE);
        spi_start   = 1'b0;
        spi_data_tx = 8'h00;
        tx_take     = '0;
        if (state == ST_LOAD) begin
            spi_start   = 1'b1;
            spi_data_tx = grant[1] ? tx1 : tx0;
            tx_take     = grant;
        end
    end

    // Transaction bookkeeping: owner, byte count, delay counter and result pulses.
    always_ff @(posedge raw_clk or posedge reset) begin
        if (reset) begin
            grant    <= '0;
            count    <= 8'd0;
            dcnt     <= 4'd0;
            last     <= 1'b1;
            rx_data  <= 8'h00;
            rx_valid <= '0;
            done     <= '0;
        end else begin
            rx_valid <= '0;
            done     <= '0;
            case (state)
                ST_IDLE: begin
                    if (grant_ok) begin
                        count <= win ? len1 : len0;
                        grant <= win ? 2'b10 : 2'b01;
                        last  <= win;
                        dcnt  <= 4'd0;
                    end
                end
                ST_SETUP: dcnt <= dcnt + 4'd1;
                ST_RUN: begin
                    if (!spi_busy) begin
                        rx_data  <= spi_data_rx;
                        rx_valid <= grant;
                        dcnt     <= 4'd0;
                        if (count != 8'd0) begin
                            count <= count - 8'd1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (dcnt == DLY_LAST) begin
                        done  <= grant;
                        grant <= '0;
                    end else begin
                        dcnt <= dcnt + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_arbiter.sv
// Bench for spi_arbiter with a behavioural byte engine and xor-ing slave.
// Latency: checks grant, byte period, rx lag, done and cs_n low time against timing rules.
// Backpressure: engine busy gates grants; a reset is dropped into a running byte.
module tb_spi_arbiter;

    localparam int D   = 2;
    localparam logic [7:0] KEY = 8'h99;

    logic       raw_clk = 1'b0;
    logic       reset   = 1'b1;
    logic [1:0] req     = 2'b00;
    logic [7:0] len0    = 8'h00;
    logic [7:0] len1    = 8'h00;
    logic [7:0] tx0     = 8'h00;
    logic [7:0] tx1     = 8'h00;
    logic [1:0] grant, tx_take, rx_valid, done;
    logic [7:0] rx_data, spi_data_tx;
    logic       cs_n, spi_start;
    logic       spi_busy    = 1'b0;
    logic [7:0] spi_data_rx = 8'h00;

    spi_arbiter #(.CS_DELAY(D)) dut (
        .raw_clk(raw_clk), .reset(reset), .req(req),
        .len0(len0), .len1(len1), .tx0(tx0), .tx1(tx1),
        .grant(grant), .tx_take(tx_take), .rx_valid(rx_valid),
        .rx_data(rx_data), .done(done), .cs_n(cs_n),
        .spi_start(spi_start), .spi_data_tx(spi_data_tx),
        .spi_busy(spi_busy), .spi_data_rx(spi_data_rx)
    );

    always #5 raw_clk = ~raw_clk;

    int n_chk = 0;
    int n_bad = 0;
    int cyc   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural engine: busy rises the edge after start, stays 17 cycles; slave answers tx^KEY.
    int         bcnt = 0;
    logic [7:0] sh   = 8'h00;
    always @(posedge raw_clk) begin
        if (spi_start && !spi_busy) begin
            spi_busy <= 1'b1;
            bcnt     <= 16;
            sh       <= spi_data_tx;
        end else if (spi_busy) begin
            if (bcnt == 0) begin
                spi_busy    <= 1'b0;
                spi_data_rx <= sh ^ KEY;
            end else begin
                bcnt <= bcnt - 1;
            end
        end
    end

    initial forever begin
        @(posedge raw_clk);
        cyc++;
    end

    // Requester byte sources.
    logic [7:0] txq0[$];
    logic [7:0] txq1[$];
    int         ptr0 = 0;
    int         ptr1 = 0;
    logic [1:0] take_seen = 2'b00;

    task automatic set_tx();
        tx0 = (ptr0 < txq0.size()) ? txq0[ptr0] : 8'h00;
        tx1 = (ptr1 < txq1.size()) ? txq1[ptr1] : 8'h00;
    endtask

    task automatic fill(input int i, input int n);
        if (i == 0) txq0.delete(); else txq1.delete();
        for (int k = 0; k < n; k++) begin
            if (i == 0) txq0.push_back(8'($urandom));
            else        txq1.push_back(8'($urandom));
        end
    endtask

    initial forever begin
        @(posedge raw_clk);
        #1;
        if (take_seen[0]) ptr0++;
        if (take_seen[1]) ptr1++;
        set_tx();
    end

    // Event monitor, sampled on the falling edge.
    logic [1:0] g_who[$];
    int         g_cyc[$];
    logic       g_busy[$];
    int         st_cyc[$];
    logic [7:0] st_dat[$];
    logic [1:0] tk_who[$];
    logic [1:0] rx_who[$];
    logic [7:0] rx_dat[$];
    int         rx_cyc[$];
    logic [1:0] dn_who[$];
    int         dn_cyc[$];
    int         cs_runs[$];
    int         cs_run    = 0;
    logic       g_prev    = 1'b0;
    logic       busy_prev = 1'b0;

    initial forever begin
        @(negedge raw_clk);
        take_seen = tx_take;
        if (grant != 2'b00 && !g_prev) begin
            g_who.push_back(grant);
            g_cyc.push_back(cyc);
            g_busy.push_back(busy_prev);
        end
        g_prev    = (grant != 2'b00);
        busy_prev = spi_busy;
        if (spi_start) begin
            st_cyc.push_back(cyc);
            st_dat.push_back(spi_data_tx);
        end
        if (tx_take != 2'b00) tk_who.push_back(tx_take);
        if (rx_valid != 2'b00) begin
            rx_who.push_back(rx_valid);
            rx_dat.push_back(rx_data);
            rx_cyc.push_back(cyc);
        end
        if (done != 2'b00) begin
            dn_who.push_back(done);
            dn_cyc.push_back(cyc);
        end
        if (!cs_n) cs_run++;
        else if (cs_run > 0) begin
            cs_runs.push_back(cs_run);
            cs_run = 0;
        end
    end

    task automatic clear_mon();
        g_who.delete(); g_cyc.delete(); g_busy.delete();
        st_cyc.delete(); st_dat.delete(); tk_who.delete();
        rx_who.delete(); rx_dat.delete(); rx_cyc.delete();
        dn_who.delete(); dn_cyc.delete(); cs_runs.delete();
        ptr0 = 0;
        ptr1 = 0;
        set_tx();
    endtask

    // Reference arbitration state: index of the last winner.
    int m_last = 1;

    function automatic int model_pick(input logic [1:0] r);
        if (r == 2'b11) return 1 - m_last;
        return r[1] ? 1 : 0;
    endfunction

    // One transaction: apply req, follow it to done, compare against the timing/data rules.
    task automatic do_txn(input logic [1:0] r, input logic [7:0] l0, input logic [7:0] l1,
                          input bit drop, input bit chk_lat);
        int         w, n, rc, tot;
        bit         seen;
        logic [7:0] expq[$];
        w      = model_pick(r);
        m_last = w;
        n      = (w == 1) ? int'(l1) + 1 : int'(l0) + 1;
        tot    = 2 * D + 19 * n;
        expq   = (w == 1) ? txq1 : txq0;
        clear_mon();
        len0 = l0;
        len1 = l1;
        @(posedge raw_clk);
        #1;
        req = r;
        rc  = cyc;
        seen = 0;
        for (int k = 0; k < 400 && !seen; k++) begin
            @(negedge raw_clk);
            if (grant != 2'b00) seen = 1;
        end
        if (!seen) chk("grant_timeout", 0, 1);
        if (drop) req = 2'b00;
        seen = 0;
        for (int k = 0; k < tot + 40 && !seen; k++) begin
            @(negedge raw_clk);
            if (done != 2'b00) seen = 1;
        end
        req = 2'b00;
        if (!seen) chk("done_timeout", 0, 1);
        repeat (3) @(negedge raw_clk);

        chk("ngrant", g_who.size(), 1);
        if (g_who.size() >= 1) begin
            chk("grant_who", g_who[0], 32'(1 << w));
            chk("grant_busy", g_busy[0], 0);
            if (chk_lat) chk("grant_lat", g_cyc[0] - rc, 1);
        end
        chk("ntake", tk_who.size(), n);
        chk("nstart", st_cyc.size(), n);
        chk("nrx", rx_dat.size(), n);
        for (int b = 0; b < n && b < st_cyc.size(); b++) begin
            chk("tx_dat", st_dat[b], expq[b]);
            if (b < tk_who.size()) chk("take_who", tk_who[b], 32'(1 << w));
            if (b > 0) chk("byte_period", st_cyc[b] - st_cyc[b-1], 19);
            if (b < rx_dat.size()) begin
                chk("rx_dat", rx_dat[b], expq[b] ^ KEY);
                chk("rx_who", rx_who[b], 32'(1 << w));
                chk("rx_lag", rx_cyc[b] - st_cyc[b], 19);
            end
        end
        chk("ndone", dn_who.size(), 1);
        if (dn_who.size() >= 1 && g_cyc.size() >= 1) begin
            chk("done_who", dn_who[0], 32'(1 << w));
            chk("done_lat", dn_cyc[0] - g_cyc[0], tot);
        end
        chk("ncs_run", cs_runs.size(), 1);
        if (cs_runs.size() >= 1) chk("cs_low", cs_runs[0], tot);
    endtask

    initial begin
        int  done_cnt, k0, k1, w;
        bit  ok;
        // Reset state.
        #12;
        chk("rst_cs_n", cs_n, 1);
        chk("rst_grant", grant, 0);
        chk("rst_start", spi_start, 0);
        chk("rst_pulses", {tx_take, rx_valid, done}, 0);
        chk("rst_rx_data", rx_data, 0);
        chk("rst_data_tx", spi_data_tx, 0);
        @(negedge raw_clk);
        reset = 1'b0;
        repeat (2) @(negedge raw_clk);

        // Single byte A5 -> 3C.
        txq0 = '{8'hA5};
        do_txn(2'b01, 8'd0, 8'd0, 0, 1);

        // Three bytes stepping 11/22/33.
        txq0 = '{8'h11, 8'h22, 8'h33};
        do_txn(2'b01, 8'd2, 8'd0, 0, 1);

        // Both requesting, held: grants alternate.
        fill(0, 2);
        fill(1, 2);
        clear_mon();
        len0 = 8'd0;
        len1 = 8'd0;
        @(posedge raw_clk);
        #1;
        req = 2'b11;
        done_cnt = 0;
        for (int k = 0; k < 300 && done_cnt < 4; k++) begin
            @(negedge raw_clk);
            if (done != 2'b00) done_cnt++;
        end
        req = 2'b00;
        chk("alt_ndone", done_cnt, 4);
        repeat (3) @(negedge raw_clk);
        k0 = 0;
        k1 = 0;
        for (int k = 0; k < 4 && k < g_who.size(); k++) begin
            w      = model_pick(2'b11);
            m_last = w;
            chk("alt_who", g_who[k], 32'(1 << w));
            if (k < rx_dat.size()) begin
                chk("alt_rx", rx_dat[k], ((w == 1) ? txq1[k1] : txq0[k0]) ^ KEY);
            end
            if (w == 1) k1++; else k0++;
            if (k < cs_runs.size()) chk("alt_cs_low", cs_runs[k], 2 * D + 19);
            if (k > 0 && k <= dn_cyc.size()) chk("alt_cs_gap", g_cyc[k] - dn_cyc[k-1], 1);
        end

        // Request dropped right after grant.
        fill(0, 3);
        do_txn(2'b01, 8'd2, 8'd0, 1, 1);

        // 256-byte burst on requester 1.
        fill(1, 256);
        do_txn(2'b10, 8'd0, 8'd255, 0, 1);

        // Reset in the middle of byte 2 of a 4-byte burst.
        fill(0, 4);
        clear_mon();
        len0 = 8'd3;
        @(posedge raw_clk);
        #1;
        req = 2'b01;
        ok = 0;
        for (int k = 0; k < 150 && !ok; k++) begin
            @(negedge raw_clk);
            if (st_cyc.size() >= 2) ok = 1;
        end
        if (!ok) chk("mid_timeout", 0, 1);
        repeat (6) @(negedge raw_clk);
        #3;
        reset = 1'b1;
        #1;
        chk("mid_cs_n", cs_n, 1);
        chk("mid_grant", grant, 0);
        chk("mid_pulses", {spi_start, tx_take, rx_valid, done}, 0);
        chk("mid_rx_cnt", rx_dat.size(), 1);
        chk("mid_busy", spi_busy, 1);
        repeat (2) @(posedge raw_clk);
        #3;
        reset  = 1'b0;
        m_last = 1;
        fill(0, 2);
        do_txn(2'b01, 8'd1, 8'd0, 0, 0);

        // Random transactions.
        for (int t = 0; t < 8; t++) begin
            logic [1:0] r;
            logic [7:0] a, b;
            r = 2'($urandom_range(1, 3));
            a = 8'($urandom_range(0, 3));
            b = 8'($urandom_range(0, 3));
            fill(0, int'(a) + 1);
            fill(1, int'(b) + 1);
            do_txn(r, a, b, bit'($urandom_range(0, 1)), 1);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
